// File: rtl/demux_1_to_4_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer.
// Latency: none (types, constants and a helper only).
// Backpressure: not applicable.
package demux_1_to_4_pkg;

  // Number of output lanes and the width of the lane select
  localparam int LANES = 4;
  localparam int SEL_W = 2;

  // Holding-register occupancy
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Lane k of a packed multi-lane bus starts at bit k*width
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/demux_1_to_4_decode_2_to_4.sv
// Select-to-one-hot decoder with enable; all-zero output when disabled.
// Latency: combinational.
// Backpressure: none, pure decode.
module decode_2_to_4
  import demux_1_to_4_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [LANES-1:0] onehot
);

  // Raise exactly the selected bit when enabled
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_1_to_4.sv
// Routes one valid/ready stream to one of four valid/ready lanes via a one-entry holding register.
// Latency: 1 cycle from accept to the word appearing on its lane; 1 word/cycle sustained.
// Backpressure: in_ready follows out_ready of the held word's lane; a stalled word holds data and lane stable.
module demux_1_to_4
  import demux_1_to_4_pkg::*;
#(
  parameter int WIDTH = 8
)
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_select,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready
);

  state_t            state;
  logic [WIDTH-1:0]  data_q;
  logic [SEL_W-1:0]  sel_q;
  logic              full;
  logic              drain;
  logic              accept;
  logic [LANES-1:0]  lane_en;

  assign full   = (state == FULL);
  // Only the held word's own consumer can free the register
  assign drain  = full & out_ready[sel_q];
  // Empty register always takes a word; a full one only when it drains this cycle
  assign in_ready = ~full | out_ready[sel_q];
  assign accept = in_valid & in_ready;

  // One decode drives both the lane valids and the data lane enables
  decode_2_to_4 u_decode (
    .en     (full),
    .sel    (sel_q),
    .onehot (lane_en)
  );

  assign out_valid = lane_en;

  // Put the held word on its lane only; every other lane reads zero
  always_comb begin
    out_data = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_en[k]) begin
        out_data[lane_lsb(k, WIDTH) +: WIDTH] = data_q;
      end
    end
  end

  // Occupancy FSM and holding registers; reset discards any held word
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      data_q <= '0;
      sel_q  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            data_q <= in_data;
            sel_q  <= in_select;
            state  <= FULL;
          end
        end
        FULL: begin
          if (drain) begin
            if (accept) begin
              // Back-to-back: replace the departing word, lane may change
              data_q <= in_data;
              sel_q  <= in_select;
            end else begin
              state <= EMPTY;
            end
          end
        end
      endcase
    end
  end

endmodule
